pc_ctrl: RTL and testbench

Parametrised program-counter unit for the MIPS fetch stage.
- Holds the architectural PC and computes next-PC for sequential, branch, jump, jump-register, return and exception flow.
- Adds stall hold, an exception/EPC mechanism and a small return-address stack (RAS) so calls and returns redirect without a register-file read.
- Sits between instruction memory addressing and the decode/control stage.

---
 rtl/pc_pkg.sv | 23 ++
 rtl/pc_ctrl_if.sv | 43 ++++
 rtl/pc_ras.sv | 49 ++++
 rtl/pc_ctrl.sv | 120 ++++++++++++
 tb/tb_pc_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program-counter unit.
package pc_pkg;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_J,
        SEL_JR,
        SEL_RET,
        SEL_EXC,
        SEL_ERET,
        SEL_HOLD
    } pc_sel_t;

    typedef enum logic {
        RUN,
        EXC
    } mode_t;

endpackage

// File: rtl/pc_ctrl_if.sv
// Fetch-side control/status bundle of the PC unit; mode and sel are debug views.
interface pc_ctrl_if #(parameter int WIDTH = 32);
    import pc_pkg::*;

    // No handshake: every input is sampled on each rising edge and must be
    // stable before it; a new pc is visible one cycle after its select.
    logic             stall;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_offset;
    logic             jump;
    logic [25:0]      jump_index;
    logic             jump_reg;
    logic [WIDTH-1:0] jump_reg_addr;
    logic             ret;
    logic             link;
    logic             exception;
    logic             eret;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] epc;
    logic             exc_mode;
    logic             ras_empty;
    logic             ras_full;
    logic             misalign;
    mode_t            mode;
    pc_sel_t          sel;

    modport master (
        output stall, branch_taken, branch_offset, jump, jump_index,
               jump_reg, jump_reg_addr, ret, link, exception, eret,
        input  pc, pc_plus4, epc, exc_mode, ras_empty, ras_full, misalign,
               mode, sel
    );

    modport slave (
        input  stall, branch_taken, branch_offset, jump, jump_index,
               jump_reg, jump_reg_addr, ret, link, exception, eret,
        output pc, pc_plus4, epc, exc_mode, ras_empty, ras_full, misalign,
               mode, sel
    );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [CW-1:0]    count;
    logic [PW-1:0]    wr_idx;
    logic             do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign top    = mem[ptr];
    assign do_pop = pop && !empty;
    // Push together with a real pop rewrites the current top in place.
    assign wr_idx = do_pop ? ptr : ptr + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && !do_pop) begin
            ptr <= ptr + 1'b1;
            if (!full) count <= count + 1'b1;
        end else if (do_pop && !push) begin
            ptr   <= ptr - 1'b1;
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= data;
    end

endmodule

// File: rtl/pc_ctrl.sv
// MIPS fetch program counter: priority next-PC mux, EPC, RUN/EXC mode FSM
// and a return-address stack for call/return prediction.
module pc_ctrl
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic      clk,
    input  logic      reset,
    pc_ctrl_if.slave  bus
);

    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] epc_reg;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] j_tgt;
    logic [WIDTH-1:0] reg_tgt;
    logic [WIDTH-1:0] ras_top;
    mode_t            mode, mode_next;
    pc_sel_t          sel;
    logic             epc_load;
    logic             push, pop;
    logic             ras_empty, ras_full;
    logic             misalign_reg, misalign_next;
    logic             eret_ok;

    assign pc_plus4 = pc_reg + WIDTH'(4);
    assign br_tgt   = pc_plus4 + (bus.branch_offset << 2);
    // Region bits above 28 come from pc+4; the low 28 bits from the index.
    assign j_tgt    = (pc_plus4 & ~WIDTH'(28'hFFF_FFFF))
                    | WIDTH'({bus.jump_index, 2'b00});
    assign reg_tgt  = {bus.jump_reg_addr[WIDTH-1:2], 2'b00};
    assign eret_ok  = bus.eret && (mode == EXC);

    always_comb begin
        sel           = SEL_SEQ;
        next_pc       = pc_plus4;
        mode_next     = mode;
        epc_load      = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        misalign_next = 1'b0;
        if (bus.exception) begin
            sel     = SEL_EXC;
            next_pc = EXC_VECTOR;
            if (mode == RUN) begin
                mode_next = EXC;
                epc_load  = 1'b1;
            end
        end else if (eret_ok) begin
            sel       = SEL_ERET;
            next_pc   = epc_reg;
            mode_next = RUN;
        end else if (bus.stall) begin
            sel     = SEL_HOLD;
            next_pc = pc_reg;
        end else begin
            push = bus.link;
            pop  = bus.ret;
            if (bus.ret && !ras_empty) begin
                sel     = SEL_RET;
                next_pc = ras_top;
            end else if (bus.ret || bus.jump_reg) begin
                sel           = bus.ret ? SEL_RET : SEL_JR;
                next_pc       = reg_tgt;
                misalign_next = |bus.jump_reg_addr[1:0];
            end else if (bus.jump) begin
                sel     = SEL_J;
                next_pc = j_tgt;
            end else if (bus.branch_taken) begin
                sel     = SEL_BR;
                next_pc = br_tgt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg       <= RESET_VECTOR;
            epc_reg      <= '0;
            mode         <= RUN;
            misalign_reg <= 1'b0;
        end else begin
            pc_reg       <= next_pc;
            mode         <= mode_next;
            misalign_reg <= misalign_next;
            if (epc_load) epc_reg <= pc_reg;
        end
    end

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .data  (pc_plus4),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    assign bus.pc        = pc_reg;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.epc       = epc_reg;
    assign bus.exc_mode  = (mode == EXC);
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
    assign bus.misalign  = misalign_reg;
    assign bus.mode      = mode;
    assign bus.sel       = sel;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: sequential flow, branch/stall, RAS calls and
// returns, exception/eret, misalignment, wrap-around and mid-run reset.
module tb_pc_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pc_ctrl_if #(.WIDTH(32)) bus ();

    pc_ctrl #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (32'h8000_0180),
        .RAS_DEPTH    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = '0;
        bus.jump          = 1'b0;
        bus.jump_index    = '0;
        bus.jump_reg      = 1'b0;
        bus.jump_reg_addr = '0;
        bus.ret           = 1'b0;
        bus.link          = 1'b0;
        bus.exception     = 1'b0;
        bus.eret          = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic jr_to(input logic [31:0] addr);
        clear_inputs();
        bus.jump_reg      = 1'b1;
        bus.jump_reg_addr = addr;
        step();
        clear_inputs();
    endtask

    logic [31:0] call_tgt [5] = '{32'h200, 32'h300, 32'h400, 32'h500, 32'h600};
    logic [31:0] ret_exp  [4] = '{32'h504, 32'h404, 32'h304, 32'h204};

    initial begin
        checks = 0;
        errors = 0;
        clear_inputs();
        reset = 1'b0;
        #12;
        check("rst_pc", bus.pc, 32'h0);
        check("rst_epc", bus.epc, 32'h0);
        check("rst_exc_mode", {31'b0, bus.exc_mode}, 32'h0);
        check("rst_ras_empty", {31'b0, bus.ras_empty}, 32'h1);
        check("rst_ras_full", {31'b0, bus.ras_full}, 32'h0);
        check("rst_misalign", {31'b0, bus.misalign}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 1; i <= 4; i++) begin
            step();
            check("seq_pc", bus.pc, 32'(4 * i));
        end

        // Branch at 0x10 with offset -2: first stalled, then taken.
        bus.branch_taken  = 1'b1;
        bus.branch_offset = 32'hFFFF_FFFE;
        bus.stall         = 1'b1;
        step();
        check("br_stall_pc", bus.pc, 32'h10);
        bus.stall = 1'b0;
        step();
        check("br_pc", bus.pc, 32'h0C);
        clear_inputs();

        jr_to(32'h100);
        check("jr_pc", bus.pc, 32'h100);
        for (int i = 0; i < 5; i++) begin
            bus.jump       = 1'b1;
            bus.link       = 1'b1;
            bus.jump_index = call_tgt[i][27:2];
            step();
            check("call_pc", bus.pc, call_tgt[i]);
        end
        clear_inputs();
        check("ras_full", {31'b0, bus.ras_full}, 32'h1);
        check("ras_not_empty", {31'b0, bus.ras_empty}, 32'h0);

        bus.ret           = 1'b1;
        bus.jump_reg_addr = 32'h1000;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ret_pc", bus.pc, ret_exp[i]);
        end
        check("ret_ras_empty", {31'b0, bus.ras_empty}, 32'h1);
        step();
        check("ret_empty_pc", bus.pc, 32'h1000);
        clear_inputs();

        jr_to(32'h40);
        bus.exception = 1'b1;
        step();
        check("exc_pc", bus.pc, 32'h8000_0180);
        check("exc_epc", bus.epc, 32'h40);
        check("exc_mode", {31'b0, bus.exc_mode}, 32'h1);
        step();
        check("exc2_pc", bus.pc, 32'h8000_0180);
        check("exc2_epc", bus.epc, 32'h40);
        check("exc2_mode", {31'b0, bus.exc_mode}, 32'h1);
        bus.exception = 1'b0;
        bus.eret      = 1'b1;
        step();
        check("eret_pc", bus.pc, 32'h40);
        check("eret_mode", {31'b0, bus.exc_mode}, 32'h0);
        step();
        check("eret_run_pc", bus.pc, 32'h44);
        clear_inputs();

        jr_to(32'h203);
        check("mis_pc", bus.pc, 32'h200);
        check("mis_pulse", {31'b0, bus.misalign}, 32'h1);
        step();
        check("mis_clear", {31'b0, bus.misalign}, 32'h0);
        check("mis_seq_pc", bus.pc, 32'h204);

        jr_to(32'hFFFF_FFFC);
        check("wrap_plus4", bus.pc_plus4, 32'h0);
        step();
        check("wrap_pc", bus.pc, 32'h0);

        // Two calls leave two entries on the stack before the mid-run reset.
        for (int i = 0; i < 2; i++) begin
            bus.jump       = 1'b1;
            bus.link       = 1'b1;
            bus.jump_index = call_tgt[i][27:2];
            step();
        end
        clear_inputs();
        check("pre_rst_ras_empty", {31'b0, bus.ras_empty}, 32'h0);
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_pc", bus.pc, 32'h0);
        check("mid_rst_ras_empty", {31'b0, bus.ras_empty}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        bus.ret           = 1'b1;
        bus.jump_reg_addr = 32'h300;
        step();
        check("post_rst_ret_pc", bus.pc, 32'h300);
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
